// File: rtl/pingpong_pkg.sv
// Shared header for the ping-pong buffer read side.
// Holds the read FSM state encoding, the bank ids and the default geometry.
// Contents: state_e, BANK0/BANK1, PP_DATA_W/PP_ADDR_W/PP_DEPTH.
package pingpong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  localparam int PP_DATA_W = 8;
  localparam int PP_ADDR_W = 4;
  localparam int PP_DEPTH  = 16;

endpackage

// File: rtl/pingpong_reader_skid_fifo2.sv
// Two-entry {last,data} FIFO that absorbs the BRAM read latency.
// Latency: a push is visible at the head on the next cycle; push and pop may coincide.
// Ports: clk_i, rst_ni (sync, active-low), push_i/push_last_i/push_data_i, pop_i,
//        count_o, head_last_o/head_data_o. The caller guarantees no push when full.
module skid_fifo2 #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              push_last_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [1:0]        count_o,
  output logic              head_last_o,
  output logic [DATA_W-1:0] head_data_o
);

  logic [DATA_W:0] mem_q [2];
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  logic [1:0]      count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o     = count_q;
  assign head_last_o = mem_q[rd_ptr_q][DATA_W];
  assign head_data_o = mem_q[rd_ptr_q][DATA_W-1:0];

endmodule

// File: rtl/pingpong_reader.sv
// Read-side controller of the two-bank ping-pong BRAM buffer: drains full banks in
// order 0,1,0,... onto a valid/ready byte stream and hands each drained bank back.
// Ports: sys_clk/sys_rst_n (sync, active-low); wr_bank_done/wr_bank_sel in;
//        rd_bank_free/rd_free_sel out; rd_en0/rd_en1/rd_addr to BRAM, rd_dout0/1 back;
//        m_data/m_valid/m_ready/m_last stream; overrun sticky error.
// Optional: define PINGPONG_CSUM_EN to add m_csum/m_csum_valid (per-bank byte sum).
module pingpong_reader
  import pingpong_pkg::*;
#(
  parameter int DATA_W = PP_DATA_W,
  parameter int ADDR_W = PP_ADDR_W,
  parameter int DEPTH  = PP_DEPTH
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              wr_bank_done,
  input  logic              wr_bank_sel,
  output logic              rd_bank_free,
  output logic              rd_free_sel,
  output logic              rd_en0,
  output logic              rd_en1,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_dout0,
  input  logic [DATA_W-1:0] rd_dout1,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              overrun
`ifdef PINGPONG_CSUM_EN
  ,
  output logic [DATA_W-1:0] m_csum,
  output logic              m_csum_valid
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_e            state_q;
  logic              cur_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_bank_free_q;
  logic              rd_free_sel_q;

  logic [1:0]        full_q, full_d;
  logic              overrun_q, overrun_d;
  logic              inflight_q, inflight_d;
  logic              infl_bank_q, infl_bank_d;
  logic              infl_last_q, infl_last_d;

  logic [1:0]        set_v, clr_v;
  logic [1:0]        fifo_count;
  logic [2:0]        occ;
  logic              pop;
  logic              rd_go;
  logic [DATA_W-1:0] push_data;

  // Stream handshake straight off the FIFO head.
  assign m_valid = (fifo_count != 2'd0);
  assign pop     = m_valid & m_ready;

  // Words already committed to the FIFO once this cycle settles. A pop in this
  // cycle frees a slot, which is what lets m_ready=1 sustain one word per clock.
  assign occ   = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_go = (state_q == ST_FETCH) && (occ < 3'd2);

  // Read enable is combinational so the word lands one cycle after FETCH issues it.
  assign rd_en0  = rd_go & (cur_q == BANK0);
  assign rd_en1  = rd_go & (cur_q == BANK1);
  assign rd_addr = rd_addr_q;

  assign rd_bank_free = rd_bank_free_q;
  assign rd_free_sel  = rd_free_sel_q;
  assign overrun      = overrun_q;

  // Bank-full bookkeeping; a done that collides with its own release keeps the bank full.
  always_comb begin
    set_v = 2'b00;
    clr_v = 2'b00;
    if (wr_bank_done) set_v[wr_bank_sel] = 1'b1;
    if (state_q == ST_RELEASE) clr_v[cur_q] = 1'b1;
    full_d    = (full_q & ~clr_v) | set_v;
    overrun_d = overrun_q | (|(set_v & full_q & ~clr_v));
  end

  // Track the one outstanding BRAM read so its word is pushed with the right bank/last.
  always_comb begin
    inflight_d  = rd_go;
    infl_bank_d = cur_q;
    infl_last_d = (rd_addr_q == LAST_ADDR);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      full_q      <= 2'b00;
      overrun_q   <= 1'b0;
      inflight_q  <= 1'b0;
      infl_bank_q <= BANK0;
      infl_last_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      overrun_q   <= overrun_d;
      inflight_q  <= inflight_d;
      infl_bank_q <= infl_bank_d;
      infl_last_q <= infl_last_d;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q        <= ST_IDLE;
      cur_q          <= BANK0;
      rd_addr_q      <= '0;
      rd_bank_free_q <= 1'b0;
      rd_free_sel_q  <= 1'b0;
    end else begin
      rd_bank_free_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (full_q[cur_q]) begin
            state_q   <= ST_FETCH;
            rd_addr_q <= '0;
          end
        end
        ST_FETCH: begin
          if (rd_go) begin
            // Address parks at the last word rather than wrapping.
            if (rd_addr_q == LAST_ADDR) state_q <= ST_DRAIN;
            else rd_addr_q <= rd_addr_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (pop && m_last) begin
            state_q        <= ST_RELEASE;
            rd_bank_free_q <= 1'b1;
            rd_free_sel_q  <= cur_q;
          end
        end
        ST_RELEASE: begin
          state_q <= ST_IDLE;
          cur_q   <= ~cur_q;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign push_data = infl_bank_q ? rd_dout1 : rd_dout0;

  skid_fifo2 #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk_i      (sys_clk),
    .rst_ni     (sys_rst_n),
    .push_i     (inflight_q),
    .push_last_i(infl_last_q),
    .push_data_i(push_data),
    .pop_i      (pop),
    .count_o    (fifo_count),
    .head_last_o(m_last),
    .head_data_o(m_data)
  );

`ifdef PINGPONG_CSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (state_q == ST_RELEASE) sum_d = '0;
    else if (pop) sum_d = sum_q + m_data;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) sum_q <= '0;
    else sum_q <= sum_d;
  end

  // The last beat is already accumulated by the time RELEASE is reached.
  assign m_csum       = sum_q;
  assign m_csum_valid = (state_q == ST_RELEASE);
`endif

endmodule

// File: tb/tb_pingpong_reader.sv
module tb_pingpong_reader;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       wr_bank_done;
  logic       wr_bank_sel;
  logic       rd_bank_free;
  logic       rd_free_sel;
  logic       rd_en0;
  logic       rd_en1;
  logic [3:0] rd_addr;
  logic [7:0] rd_dout0;
  logic [7:0] rd_dout1;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       overrun;
`ifdef PINGPONG_CSUM_EN
  logic [7:0] m_csum;
  logic       m_csum_valid;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0] bq[$];     // transferred beats {last,data}
  logic       fq[$];     // released bank ids
  int         issued = 0;
  int         xfer = 0;
  int         credit_viol = 0;

  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];

  always #5 sys_clk = ~sys_clk;

  pingpong_reader dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .wr_bank_done(wr_bank_done),
    .wr_bank_sel (wr_bank_sel),
    .rd_bank_free(rd_bank_free),
    .rd_free_sel (rd_free_sel),
    .rd_en0      (rd_en0),
    .rd_en1      (rd_en1),
    .rd_addr     (rd_addr),
    .rd_dout0    (rd_dout0),
    .rd_dout1    (rd_dout1),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_last      (m_last),
    .overrun     (overrun)
`ifdef PINGPONG_CSUM_EN
    ,
    .m_csum      (m_csum),
    .m_csum_valid(m_csum_valid)
`endif
  );

  // BRAM model: one-cycle read latency per bank.
  always @(posedge sys_clk) begin
    if (rd_en0) rd_dout0 <= mem0[rd_addr];
    if (rd_en1) rd_dout1 <= mem1[rd_addr];
  end

  // Observer on the falling edge: beats, frees and read-ahead bound.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      issued = 0;
      xfer = 0;
    end else begin
      if (rd_en0 || rd_en1) issued++;
      if (m_valid && m_ready) begin
        bq.push_back({m_last, m_data});
        xfer++;
      end
      if (issued - xfer > 2) credit_viol++;
      if (rd_bank_free) fq.push_back(rd_free_sel);
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    wr_bank_done = 1'b0;
    wr_bank_sel = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b1;
    bq.delete();
    fq.delete();
  endtask

  task automatic pulse_done(input logic sel);
    wr_bank_done = 1'b1;
    wr_bank_sel = sel;
    tick();
    wr_bank_done = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget, input string tag);
    int k = 0;
    while (bq.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 32'(bq.size() >= n), 32'd1);
  endtask

  // Compare 16 beats starting at queue index base against one bank image.
  task automatic chk_bank(input int base, input logic bank, input string tag);
    logic [8:0] got;
    logic [8:0] exp;
    for (int i = 0; i < 16; i++) begin
      got = (base + i < bq.size()) ? bq[base+i] : 9'h1FF;
      exp = {(i == 15), (bank ? 8'h40 : 8'h00) + 8'(i)};
      chk($sformatf("%s_beat%0d", tag, i), 32'(got), 32'(exp));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem0[i] = 8'(i);
      mem1[i] = 8'h40 + 8'(i);
    end
    rd_dout0 = 8'h00;
    rd_dout1 = 8'h00;
    m_ready = 1'b1;

    // Reset values
    do_reset();
    chk("rst_outputs",
        32'({rd_bank_free, rd_free_sel, rd_en0, rd_en1, rd_addr, m_data, m_valid, m_last, overrun}),
        32'd0);

    // Test 1: single bank 0 at full rate
    pulse_done(1'b0);
    wait_beats(16, 60, "t1_beats_arrive");
    chk("t1_free_pulse", 32'(rd_bank_free), 32'd1);
    chk("t1_free_sel", 32'(rd_free_sel), 32'd0);
`ifdef PINGPONG_CSUM_EN
    chk("t6_csum_valid", 32'(m_csum_valid), 32'd1);
    chk("t6_csum", 32'(m_csum), 32'h78);
`endif
    chk_bank(0, 1'b0, "t1");
    repeat (6) tick();
    chk("t1_beat_count", 32'(bq.size()), 32'd16);
    chk("t1_no_overrun", 32'(overrun), 32'd0);

    // Test 2: both banks back-to-back
    do_reset();
    pulse_done(1'b0);
    pulse_done(1'b1);
    wait_beats(32, 120, "t2_beats_arrive");
    repeat (4) tick();
    chk("t2_beat_count", 32'(bq.size()), 32'd32);
    chk_bank(0, 1'b0, "t2_b0");
    chk_bank(16, 1'b1, "t2_b1");
    chk("t2_free_count", 32'(fq.size()), 32'd2);
    if (fq.size() == 2) begin
      chk("t2_free0", 32'(fq[0]), 32'd0);
      chk("t2_free1", 32'(fq[1]), 32'd1);
    end

    // Test 3: ready toggling with two 5-clock stalls
    do_reset();
    credit_viol = 0;
    pulse_done(1'b0);
    for (int j = 0; j < 200 && bq.size() < 16; j++) begin
      m_ready = ((j % 2) == 0) && !(j >= 6 && j <= 10) && !(j >= 20 && j <= 24);
      tick();
    end
    m_ready = 1'b1;
    chk("t3_beats_arrive", 32'(bq.size() >= 16), 32'd1);
    chk_bank(0, 1'b0, "t3");
    repeat (4) tick();
    chk("t3_free_sel", 32'(fq.size() == 1 && fq[0] == 1'b0), 32'd1);
    chk("t3_readahead_bound", 32'(credit_viol), 32'd0);

    // Test 4: second done on a still-full bank
    do_reset();
    pulse_done(1'b0);
    tick();
    tick();
    pulse_done(1'b0);
    tick();
    chk("t4_overrun_set", 32'(overrun), 32'd1);
    wait_beats(16, 60, "t4_beats_arrive");
    repeat (8) tick();
    chk("t4_beat_count", 32'(bq.size()), 32'd16);
    chk_bank(0, 1'b0, "t4");
    chk("t4_overrun_sticky", 32'(overrun), 32'd1);

    // Done on the bank being released in that same cycle: no overrun, bank refilled
    do_reset();
    pulse_done(1'b0);
    for (int k = 0; k < 60 && !rd_bank_free; k++) tick();
    chk("t4b_in_release", 32'(rd_bank_free), 32'd1);
    pulse_done(1'b0);
    chk("t4b_no_overrun", 32'(overrun), 32'd0);
    pulse_done(1'b1);
    wait_beats(48, 150, "t4b_beats_arrive");
    chk_bank(16, 1'b1, "t4b_b1");
    chk_bank(32, 1'b0, "t4b_b0");
    chk("t4b_no_overrun_end", 32'(overrun), 32'd0);

    // Test 5: reset mid-bank
    do_reset();
    pulse_done(1'b0);
    wait_beats(7, 40, "t5_seven_beats");
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    chk("t5_rst_outputs",
        32'({rd_bank_free, rd_free_sel, rd_en0, rd_en1, rd_addr, m_data, m_valid, m_last, overrun}),
        32'd0);
    bq.delete();
    fq.delete();
    repeat (5) tick();
    chk("t5_no_stale_beats", 32'(bq.size()), 32'd0);
    pulse_done(1'b0);
    wait_beats(16, 60, "t5_restart_beats");
    chk_bank(0, 1'b0, "t5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
